// File: rtl/monopix_pkg.sv
// Shared types, widths and data-word packing for the MONOPIX matrix/readout model.
package monopix_pkg;

  localparam int unsigned N_COL  = 36;
  localparam int unsigned N_ROW  = 129;
  localparam int unsigned TS_W   = 8;
  localparam int unsigned COL_W  = 6;
  localparam int unsigned ROW_W  = 8;
  localparam int unsigned N_PIX  = N_COL * N_ROW;
  localparam int unsigned IDX_W  = $clog2(N_PIX);
  localparam int unsigned DATA_W = COL_W + ROW_W + 2 * TS_W;

  // Alternating 10 pattern, MSB first, truncated to the data word width
  localparam logic [DATA_W-1:0] TEST_WORD = DATA_W'({(DATA_W / 2 + 1){2'b10}} >> 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    READY = 2'd2
  } pix_state_t;

  function automatic logic [DATA_W-1:0] pack_word(
    input logic [COL_W-1:0] col,
    input logic [ROW_W-1:0] row,
    input logic [TS_W-1:0]  le,
    input logic [TS_W-1:0]  te
  );
    return {col, row, le, te};
  endfunction

endpackage

// File: rtl/monopix_pixel.sv
// One MONOPIX pixel: edge detection on the discriminated hit and an
// IDLE/BUSY/READY capture FSM holding leading/trailing-edge gray timestamps.
module monopix_pixel
  import monopix_pkg::*;
(
  input  logic            Clk_BX,
  input  logic            Reset,
  input  logic            i_hit,
  input  logic            i_freeze,
  input  logic [TS_W-1:0] i_gray,
  input  logic            i_pop,
  output logic            o_ready,
  output logic [TS_W-1:0] o_le,
  output logic [TS_W-1:0] o_te
);

  pix_state_t r_state;
  logic       r_hit_d;
  logic       w_rise;
  logic       w_fall;

  assign w_rise  = i_hit & ~r_hit_d;
  assign w_fall  = ~i_hit & r_hit_d;
  assign o_ready = (r_state == READY);

  always_ff @(posedge Clk_BX) begin
    if (Reset) begin
      r_state <= IDLE;
      r_hit_d <= 1'b0;
      o_le    <= '0;
      o_te    <= '0;
    end else begin
      r_hit_d <= i_hit;
      case (r_state)
        IDLE: begin
          if (w_rise && !i_freeze) begin
            r_state <= BUSY;
            o_le    <= i_gray;
          end
        end
        // Trailing edge is captured regardless of FREEZE
        BUSY: begin
          if (w_fall) begin
            r_state <= READY;
            o_te    <= i_gray;
          end
        end
        READY: begin
          if (i_pop) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/monopix_readout_model.sv
// MONOPIX matrix + token readout: gray timestamp counter, pixel array,
// lowest-index priority pop on READ rising edge. Optional MONOPIX_TEST_PATTERN_EN.
module monopix_readout_model
  import monopix_pkg::*;
(
  input  logic              Clk_BX,
  input  logic              Reset,
  input  logic [N_PIX-1:0]  ANA_HIT,
  input  logic              Injection,
  input  logic [N_PIX-1:0]  INJ_EN,
  input  logic [N_PIX-1:0]  PIX_EN,
  input  logic              RST_Gray,
  input  logic              FREEZE,
  input  logic              READ,
  input  logic              EN_Test_Pattern,
  output logic              Token_Out,
  output logic [DATA_W-1:0] Data_Out
);

  logic [TS_W-1:0]  r_cnt;
  logic             r_read_d;
  logic [TS_W-1:0]  w_gray;
  logic [N_PIX-1:0] w_hit;
  logic [N_PIX-1:0] w_ready;
  logic [N_PIX-1:0] w_pop;
  logic [TS_W-1:0]  w_le [N_PIX];
  logic [TS_W-1:0]  w_te [N_PIX];
  logic             w_read_rise;
  logic             w_tp;
  logic             w_pop_px;
  logic             w_found;
  logic [IDX_W-1:0] w_sel_idx;
  logic [COL_W-1:0] w_sel_col;
  logic [ROW_W-1:0] w_sel_row;

  assign w_gray      = r_cnt ^ (r_cnt >> 1);
  assign w_hit       = PIX_EN & (ANA_HIT | ({N_PIX{Injection}} & INJ_EN));
  assign w_read_rise = READ & ~r_read_d;

`ifdef MONOPIX_TEST_PATTERN_EN
  assign w_tp = w_read_rise & EN_Test_Pattern;
`else
  logic w_unused_tp;
  assign w_unused_tp = EN_Test_Pattern;
  assign w_tp        = 1'b0;
`endif

  assign w_pop_px = w_read_rise & ~w_tp & w_found;

  // Column/row are tracked by the nested loop so no divider is needed
  always_comb begin
    w_found   = 1'b0;
    w_sel_idx = '0;
    w_sel_col = '0;
    w_sel_row = '0;
    for (int unsigned c = 0; c < N_COL; c++) begin
      for (int unsigned r = 0; r < N_ROW; r++) begin
        if (!w_found && w_ready[IDX_W'(c * N_ROW + r)]) begin
          w_found   = 1'b1;
          w_sel_idx = IDX_W'(c * N_ROW + r);
          w_sel_col = COL_W'(c);
          w_sel_row = ROW_W'(r);
        end
      end
    end
  end

  for (genvar g = 0; g < N_PIX; g++) begin : g_pix
    assign w_pop[g] = w_pop_px && (w_sel_idx == IDX_W'(g));

    monopix_pixel u_pix (
      .Clk_BX   (Clk_BX),
      .Reset    (Reset),
      .i_hit    (w_hit[g]),
      .i_freeze (FREEZE),
      .i_gray   (w_gray),
      .i_pop    (w_pop[g]),
      .o_ready  (w_ready[g]),
      .o_le     (w_le[g]),
      .o_te     (w_te[g])
    );
  end

  always_ff @(posedge Clk_BX) begin
    if (Reset) begin
      r_cnt     <= '0;
      r_read_d  <= 1'b0;
      Token_Out <= 1'b0;
      Data_Out  <= '0;
    end else begin
      r_cnt     <= RST_Gray ? '0 : r_cnt + TS_W'(1);
      r_read_d  <= READ;
      Token_Out <= |w_ready;
      if (w_tp) begin
        Data_Out <= TEST_WORD;
      end else if (w_read_rise) begin
        Data_Out <= w_found ? pack_word(w_sel_col, w_sel_row, w_le[w_sel_idx], w_te[w_sel_idx])
                            : '0;
      end
    end
  end

endmodule

// File: tb/tb_monopix_readout_model.sv
// Bench for monopix_readout_model: spec-level behavioural model checked every
// cycle, plus directed literal expectations.
module tb_monopix_readout_model;
  import monopix_pkg::*;

  logic              clk = 1'b0;
  logic              Reset = 1'b1;
  logic [N_PIX-1:0]  ANA_HIT = '0;
  logic              Injection = 1'b0;
  logic [N_PIX-1:0]  INJ_EN = '0;
  logic [N_PIX-1:0]  PIX_EN = '1;
  logic              RST_Gray = 1'b0;
  logic              FREEZE = 1'b0;
  logic              READ = 1'b0;
  logic              EN_Test_Pattern = 1'b0;
  logic              Token_Out;
  logic [DATA_W-1:0] Data_Out;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  always #5 clk = ~clk;

  monopix_readout_model dut (
    .Clk_BX          (clk),
    .Reset           (Reset),
    .ANA_HIT         (ANA_HIT),
    .Injection       (Injection),
    .INJ_EN          (INJ_EN),
    .PIX_EN          (PIX_EN),
    .RST_Gray        (RST_Gray),
    .FREEZE          (FREEZE),
    .READ            (READ),
    .EN_Test_Pattern (EN_Test_Pattern),
    .Token_Out       (Token_Out),
    .Data_Out        (Data_Out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_pulse();
    READ = 1'b1;
    tick();
    READ = 1'b0;
  endtask

  // ---------------- behavioural model ----------------
  // pixel status: 0 = waiting for leading edge, 1 = leading edge stored, 2 = complete hit
  int                m_st [N_PIX];
  int                m_le [N_PIX];
  int                m_te [N_PIX];
  bit                m_hd [N_PIX];
  int                m_cnt = 0;
  bit                m_read_d = 0;
  bit                m_token = 0;
  logic [DATA_W-1:0] m_data = '0;

  function automatic int gray_of(input int v);
    return v ^ (v >> 1);
  endfunction

  always @(posedge clk) begin : model
    int  sel;
    int  g;
    bit  any;
    bit  h;
    if (Reset) begin
      for (int i = 0; i < N_PIX; i++) begin
        m_st[i] = 0; m_le[i] = 0; m_te[i] = 0; m_hd[i] = 0;
      end
      m_cnt = 0; m_read_d = 0; m_token = 0; m_data = '0;
    end else begin
      g   = gray_of(m_cnt);
      sel = -1;
      any = 0;
      for (int i = 0; i < N_PIX; i++)
        if (m_st[i] == 2) begin
          any = 1;
          if (sel < 0) sel = i;
        end
      if (READ && !m_read_d) begin
`ifdef MONOPIX_TEST_PATTERN_EN
        if (EN_Test_Pattern) begin
          m_data = 30'h2AAA_AAAA;
          sel    = -1;
        end else
`endif
        if (sel >= 0)
          m_data = DATA_W'(((sel / N_ROW) << (ROW_W + 2 * TS_W)) | ((sel % N_ROW) << (2 * TS_W))
                           | (m_le[sel] << TS_W) | m_te[sel]);
        else
          m_data = '0;
      end else begin
        sel = -1;
      end
      m_token = any;
      for (int i = 0; i < N_PIX; i++) begin
        h = PIX_EN[i] & (ANA_HIT[i] | (Injection & INJ_EN[i]));
        if (m_st[i] == 0 && h && !m_hd[i] && !FREEZE) begin
          m_st[i] = 1; m_le[i] = g;
        end else if (m_st[i] == 1 && !h && m_hd[i]) begin
          m_st[i] = 2; m_te[i] = g;
        end else if (m_st[i] == 2 && i == sel) begin
          m_st[i] = 0;
        end
        m_hd[i] = h;
      end
      m_read_d = READ;
      m_cnt    = RST_Gray ? 0 : (m_cnt + 1) % (1 << TS_W);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("token_vs_model", 32'(Token_Out), 32'(m_token));
      chk("data_vs_model", 32'(Data_Out), 32'(m_data));
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    tick(3);
    chk_en = 1;
    chk("reset_token", 32'(Token_Out), 32'h0);
    chk("reset_data", 32'(Data_Out), 32'h0);
    chk("reset_gray", 32'(dut.w_gray), 32'h0);
    Reset = 1'b0;

    // gray counter and RST_Gray
    tick(5);
    chk("gray_cnt5", 32'(dut.w_gray), 32'h07);
    RST_Gray = 1'b1;
    tick();
    RST_Gray = 1'b0;
    chk("gray_after_rst0", 32'(dut.w_gray), 32'h00);
    tick();
    chk("gray_after_rst1", 32'(dut.w_gray), 32'h01);
    tick();
    chk("gray_after_rst2", 32'(dut.w_gray), 32'h03);
    tick();
    chk("gray_after_rst3", 32'(dut.w_gray), 32'h02);

    // single hit on pixel 0: LE at gray 03, TE at gray 06
    RST_Gray = 1'b1;
    tick();
    RST_Gray = 1'b0;
    tick(2);
    ANA_HIT[0] = 1'b1;
    tick(2);
    ANA_HIT[0] = 1'b0;
    tick();
    chk("t2_token_latency", 32'(Token_Out), 32'h0);
    tick();
    chk("t2_token_set", 32'(Token_Out), 32'h1);
    read_pulse();
    chk("t2_data", 32'(Data_Out), 32'h0000_0306);
    tick();
    chk("t2_token_clear", 32'(Token_Out), 32'h0);
    chk("t2_data_hold", 32'(Data_Out), 32'h0000_0306);

    // priority: pixels 5 and 130, READ held high pops once
    ANA_HIT[5]   = 1'b1;
    ANA_HIT[130] = 1'b1;
    tick();
    ANA_HIT[5]   = 1'b0;
    ANA_HIT[130] = 1'b0;
    tick(2);
    READ = 1'b1;
    tick();
    chk("t3_first_colrow", 32'(Data_Out[DATA_W-1 -: 14]), 32'h005);
    tick(2);
    chk("t3_held_colrow", 32'(Data_Out[DATA_W-1 -: 14]), 32'h005);
    chk("t3_held_token", 32'(Token_Out), 32'h1);
    READ = 1'b0;
    tick();
    read_pulse();
    chk("t3_second_colrow", 32'(Data_Out[DATA_W-1 -: 14]), 32'h101);
    tick();
    read_pulse();
    chk("t3_empty_pop", 32'(Data_Out), 32'h0);
    tick();

    // FREEZE blocks leading edges but not trailing edges
    FREEZE = 1'b1;
    ANA_HIT[7] = 1'b1;
    tick(2);
    ANA_HIT[7] = 1'b0;
    tick(3);
    chk("t4_frozen_token", 32'(Token_Out), 32'h0);
    FREEZE = 1'b0;
    ANA_HIT[8] = 1'b1;
    tick();
    FREEZE = 1'b1;
    ANA_HIT[8] = 1'b0;
    tick(2);
    chk("t4_busy_completes", 32'(Token_Out), 32'h1);
    read_pulse();
    chk("t4_colrow", 32'(Data_Out[DATA_W-1 -: 14]), 32'h008);
    FREEZE = 1'b0;
    tick();

    // injection gated by PIX_EN
    PIX_EN[10] = 1'b0;
    INJ_EN[10] = 1'b1;
    Injection  = 1'b1;
    tick(2);
    Injection  = 1'b0;
    tick(3);
    chk("t5_masked_token", 32'(Token_Out), 32'h0);
    PIX_EN[10] = 1'b1;
    Injection  = 1'b1;
    tick(2);
    Injection  = 1'b0;
    tick(2);
    chk("t5_inj_token", 32'(Token_Out), 32'h1);
    read_pulse();
    chk("t5_colrow", 32'(Data_Out[DATA_W-1 -: 14]), 32'h00A);
    INJ_EN[10] = 1'b0;
    tick();

    // pixel completing in the pop cycle is not eligible
    ANA_HIT[20] = 1'b1;
    tick();
    ANA_HIT[20] = 1'b0;
    READ = 1'b1;
    tick();
    READ = 1'b0;
    chk("same_cycle_not_eligible", 32'(Data_Out), 32'h0);
    tick();
    read_pulse();
    chk("late_pixel_colrow", 32'(Data_Out[DATA_W-1 -: 14]), 32'h014);
    tick();

    // test pattern
    ANA_HIT[3] = 1'b1;
    tick();
    ANA_HIT[3] = 1'b0;
    tick(2);
    EN_Test_Pattern = 1'b1;
    read_pulse();
    EN_Test_Pattern = 1'b0;
`ifdef MONOPIX_TEST_PATTERN_EN
    chk("t6_pattern", 32'(Data_Out), 32'h2AAA_AAAA);
    tick(2);
    chk("t6_retained_token", 32'(Token_Out), 32'h1);
    read_pulse();
    chk("t6_after_colrow", 32'(Data_Out[DATA_W-1 -: 14]), 32'h003);
    tick();
`else
    chk("t6_ignored_colrow", 32'(Data_Out[DATA_W-1 -: 14]), 32'h003);
    tick(2);
    chk("t6_ignored_token", 32'(Token_Out), 32'h0);
`endif

    // counter wrap
    RST_Gray = 1'b1;
    tick();
    RST_Gray = 1'b0;
    tick(255);
    chk("gray_cnt255", 32'(dut.w_gray), 32'h80);
    tick();
    chk("gray_wrap", 32'(dut.w_gray), 32'h00);

    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
